// File: rtl/ahb_apb_bridge_nslv.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge_nslv
//   AHB-Lite slave to APB master bridge fanning out to NUM_SLV APB slaves.
//   Each slave owns a 2^SLV_AW byte window; the window number selects psel.
//   One AHB transfer maps to one APB transfer:
//     read  : SETUP, ACCESS
//     write : WDATA, SETUP, ACCESS
//   The bridge answers with a two-cycle ERROR in three cases: an unmapped
//   window, an oversize hsize, or an APB slave error. An APB access that
//   stays stalled for TIMEOUT cycles is also aborted with that ERROR.
//
// Ports
//   hclk_i, hreset_i          clock, asynchronous active-high reset
//   hsel_i .. hreadyin_i      AHB request side (address/control/write data)
//   hrdata_o, hreadyout_o,
//   hresp_o                   AHB response side
//   psel_o .. pwdata_o        APB request side (psel one-hot per slave)
//   prdata_i, pready_i,
//   pslverr_i                 APB response side (shared by all slaves)
// ---------------------------------------------------------------------------
module ahb_apb_bridge_nslv #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SLV_AW  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              hclk_i,
    input  logic              hreset_i,
    // AHB
    input  logic              hsel_i,
    input  logic [ADDR_W-1:0] haddr_i,
    input  logic [1:0]        htrans_i,
    input  logic              hwrite_i,
    input  logic [2:0]        hsize_i,
    input  logic [DATA_W-1:0] hwdata_i,
    input  logic              hreadyin_i,
    output logic [DATA_W-1:0] hrdata_o,
    output logic              hreadyout_o,
    output logic [1:0]        hresp_o,
    // APB
    output logic [NUM_SLV-1:0] psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    // The window number is decoded over 4 bits (enough for 16 slaves) so
    // that windows beyond NUM_SLV are caught as unmapped rather than
    // aliasing onto a real slave through a truncated index.
    localparam int DEC_W = 4;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0]       MAX_SIZE = 3'($clog2(DATA_W / 8));
    localparam logic [DEC_W:0]   SLV_LIM  = 5'(NUM_SLV);
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT);

    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [NUM_SLV-1:0] psel_q, psel_d;
    logic               penable_q;
    logic               pwrite_q;
    logic [ADDR_W-1:0]  paddr_q;
    logic [DATA_W-1:0]  pwdata_q;
    logic [DATA_W-1:0]  hrdata_q;
    logic               hready_q;
    logic [1:0]         hresp_q;

    logic               xfer_valid;
    logic               legal;
    logic               load;
    logic               acc_ok;
    logic [DEC_W-1:0]   dec;

    // -----------------------------------------------------------------------
    // Request decode and next state
    // -----------------------------------------------------------------------
    always_comb begin
        xfer_valid = hsel_i && hreadyin_i &&
                     ((htrans_i == HT_NONSEQ) || (htrans_i == HT_SEQ));
        dec        = haddr_i[SLV_AW +: DEC_W];
        legal      = ({1'b0, dec} < SLV_LIM) && (hsize_i <= MAX_SIZE);
        acc_ok     = (state_q == S_ACCESS) && pready_i && !pslverr_i;

        state_d = state_q;
        load    = 1'b0;
        wcnt_d  = '0;

        case (state_q)
            S_IDLE, S_ERR2: begin
                state_d = S_IDLE;
                load    = xfer_valid;
            end
            S_WDATA: state_d = S_SETUP;
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (pready_i) begin
                    if (pslverr_i) begin
                        state_d = S_ERR1;
                    end else begin
                        // Completion cycle has hreadyout high, so the next
                        // address phase is taken here without an IDLE gap.
                        state_d = S_IDLE;
                        load    = xfer_valid;
                    end
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                    if (wcnt_d == TO_LIM) begin
                        state_d = S_ERR1;
                    end
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            state_d = !legal ? S_ERR1 : (hwrite_i ? S_WDATA : S_SETUP);
        end

        idx_d = load ? dec[IDX_W-1:0] : idx_q;

        for (int i = 0; i < NUM_SLV; i++) begin
            psel_d[i] = ((state_d == S_SETUP) || (state_d == S_ACCESS)) &&
                        (idx_d == IDX_W'(i));
        end
    end

    // -----------------------------------------------------------------------
    // State and registered outputs (all decoded from the next state)
    // -----------------------------------------------------------------------
    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wcnt_q    <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            hrdata_q  <= '0;
            hready_q  <= 1'b1;
            hresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wcnt_q    <= wcnt_d;
            psel_q    <= psel_d;
            penable_q <= (state_d == S_ACCESS);
            hready_q  <= (state_d == S_IDLE) || (state_d == S_ERR2);
            hresp_q   <= ((state_d == S_ERR1) || (state_d == S_ERR2)) ?
                         RESP_ERR : RESP_OKAY;
            if (load) begin
                paddr_q  <= haddr_i;
                pwrite_q <= hwrite_i;
            end
            // hwdata belongs to the data phase, i.e. the WDATA cycle.
            if (state_q == S_WDATA) begin
                pwdata_q <= hwdata_i;
            end
            if (acc_ok && !pwrite_q) begin
                hrdata_q <= prdata_i;
            end
        end
    end

    // Completion is reported in the same cycle pready arrives, so the
    // ready/read-data path from APB to AHB is combinational there only.
    assign hreadyout_o = hready_q || acc_ok;
    assign hrdata_o    = (acc_ok && !pwrite_q) ? prdata_i : hrdata_q;
    assign hresp_o     = hresp_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;

endmodule

// File: doc/ahb_apb_bridge_nslv.md
AHB_APB_BRIDGE_NSLV -- requirements
Module: ahb_apb_bridge_nslv

Interface
REQ-001 Parameter ADDR_W, 32, address width of haddr/paddr.
REQ-002 Parameter DATA_W, 32, data width; legal values 8/16/32/64.
REQ-003 Parameter NUM_SLV, 4, number of APB slaves (1-16); IDX_W = max(1, clog2(NUM_SLV)).
REQ-004 Parameter SLV_AW, 12, slave window size 2^SLV_AW bytes; slave index = haddr[SLV_AW +: IDX_W].
REQ-005 Parameter TIMEOUT, 16, max ACCESS cycles with pready low before abort (>=2).
REQ-006 hclk  in  1  single clock, all logic on rising edge.
REQ-007 hreset  in  1  asynchronous, active-high reset.
REQ-008 hsel  in  1  bridge select; haddr  in  ADDR_W; htrans  in  2 (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ); hwrite  in  1; hsize  in  3; hwdata  in  DATA_W; hreadyin  in  1.
REQ-009 hrdata  out  DATA_W; hreadyout  out  1; hresp  out  2 (00 OKAY, 01 ERROR).
REQ-010 psel  out  NUM_SLV one-hot; penable  out  1; pwrite  out  1; paddr  out  ADDR_W; pwdata  out  DATA_W.
REQ-011 prdata  in  DATA_W; pready  in  1; pslverr  in  1.

Function
REQ-012 Valid transfer SHALL be hsel & hreadyin & htrans in {NONSEQ, SEQ}; IDLE/BUSY SHALL be ignored with OKAY, zero wait.
REQ-013 States SHALL be IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
REQ-014 Address, hwrite, slave index SHALL be registered when a valid transfer is sampled in IDLE, in ACCESS completing OKAY, or in ERR2.
REQ-015 Sampled transfer with index >= NUM_SLV or hsize > clog2(DATA_W/8) SHALL go to ERR1 with no psel asserted.
REQ-016 Legal write SHALL go to WDATA (hreadyout=0, hwdata registered into pwdata at cycle end), then SETUP.
REQ-017 Legal read SHALL go directly to SETUP.
REQ-018 SETUP: psel[idx]=1, penable=0, paddr/pwrite from registers, hreadyout=0; next state ACCESS unconditionally.
REQ-019 ACCESS: psel[idx]=1, penable=1, paddr/pwrite/pwdata held stable; wait counter increments each cycle pready=0.
REQ-020 ACCESS with pready=1, pslverr=0: hreadyout=1, hresp=OKAY; on reads hrdata=prdata in that cycle and the value is held in a register afterwards; next state per REQ-014 or IDLE.
REQ-021 ACCESS with pready=1, pslverr=1: hreadyout=0, next state ERR1.
REQ-022 Wait counter reaching TIMEOUT with pready=0: psel/penable deassert next cycle, next state ERR1.
REQ-023 ERR1: hresp=ERROR, hreadyout=0, psel=0; ERR2: hresp=ERROR, hreadyout=1; ERR2 then IDLE or new transfer.
REQ-024 IDLE: psel=0, penable=0, hreadyout=1, hresp=OKAY.
REQ-025 Minimum latency: read 2 bridge cycles after address phase (SETUP, ACCESS), write 3 (WDATA, SETUP, ACCESS); back-to-back transfers SHALL incur no extra IDLE cycle.
REQ-026 psel SHALL never have more than one bit set; penable SHALL only be high when psel is non-zero.
REQ-027 hreadyin=0 in IDLE SHALL block sampling; transfer is sampled when hreadyin returns high.

Reset
REQ-028 hreset high SHALL immediately force state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0, hreadyout=1, hresp=OKAY, wait counter=0, including mid-transfer.
REQ-029 After hreset deasserts, first valid transfer SHALL be accepted on the next rising edge.

Verification
REQ-030 Write haddr=0x0000_1004, hwdata=0xDEADBEEF, pready=1 -> psel=0b0010, paddr=0x1004, pwdata=0xDEADBEEF, hreadyout high in ACCESS, OKAY.
REQ-031 Read haddr=0x0000_3010, prdata=0x12345678, pready low 3 cycles -> psel=0b1000, 3 wait cycles, hrdata=0x12345678, OKAY.
REQ-032 Read then write back-to-back (SEQ) to slave 0 -> SETUP follows completion with no IDLE; ordering and data correct.
REQ-033 haddr=0x0000_5000 (index 5, NUM_SLV=4) -> no psel, ERR1 then ERR2, hresp=01.
REQ-034 pslverr=1 on write completion -> two-cycle ERROR; pready held low 16 cycles -> abort, two-cycle ERROR.
REQ-035 hreset pulsed in ACCESS -> psel/penable low immediately; next transfer completes normally.
